fragment_shade_stage: RTL and testbench
=======================================

Name: fragment_shade_stage

Overview:
Parametrised fragment shading stage between the rasterizer and the depth-tested framebuffer writer. It converts fixed-point fragment coordinates to integer pixel/depth values and discards off-screen fragments. Colour comes from one of four selectable modes: flat, per-triangle palette, depth-shaded palette, or triangle-ID debug. The block adds valid/ready backpressure, a writable palette and fragment/clip statistics counters.

Parameters:
COORD_WIDTH, 17, width of each fixed-point fragment coordinate
FRAC_BITS, 8, fractional bits of x/y coordinates
X_WIDTH, 9, output pixel x width
Y_WIDTH, 8, output pixel y width
Z_WIDTH, 8, output depth width
Z_LSB, 9, lowest coordinate bit taken for depth
ID_WIDTH, 16, triangle id width
SCREEN_WIDTH, 320, x clip bound (exclusive)
SCREEN_HEIGHT, 240, y clip bound (exclusive)
PALETTE_DEPTH, 16, palette entries (power of two)
FLAT_COLOR, 12'hAAA, colour in FLAT mode

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
valid_in  input  1  fragment valid
ready_out  output  1  stage can accept fragment
triangle_id_in  input  ID_WIDTH  owning triangle
fragment_in  input  3 x COORD_WIDTH  {z,y,x}; [0]=x, [1]=y, [2]=z
mode_in  input  2  0 FLAT, 1 PALETTE, 2 DEPTH_SHADE, 3 ID_DEBUG
pal_we_in  input  1  palette write strobe
pal_addr_in  input  log2(PALETTE_DEPTH)  palette write address
pal_data_in  input  12  palette RGB444
frame_start_in  input  1  clears counters
valid_out  output  1  shaded pixel valid
ready_in  input  1  downstream accepts
x_out  output  X_WIDTH  pixel x
y_out  output  Y_WIDTH  pixel y
z_out  output  Z_WIDTH  depth
rgb_out  output  12  RGB444
frag_count_out  output  32  pixels handed off since frame start
clip_count_out  output  32  fragments discarded since frame start

Behaviour:
- One clock (clk_in); reset synchronous, active-high (rst_in).
- Reset: valid_out=0, all internal stage valids=0, x/y/z/rgb_out=0, both counters=0. The palette contents are not reset. Reset mid-stream drops all in-flight fragments.
- Three-stage pipeline, global advance en = !valid_out || ready_in. ready_out = en. An input is accepted when valid_in && ready_out. Latency: accept at cycle N -> valid_out at N+3 with no stalls.
- While stalled (valid_out && !ready_in), all stages and outputs hold stable.
- S1 (decode and clip):
  - xi = fragment_in[0] >> FRAC_BITS; yi = fragment_in[1] >> FRAC_BITS.
  - z = fragment_in[2][Z_LSB+Z_WIDTH-1:Z_LSB].
  - Clip when xi >= SCREEN_WIDTH or yi >= SCREEN_HEIGHT. A clipped fragment becomes a bubble and increments clip_count_out.
  - Otherwise latch truncated x/y/z, mode_in, triangle_id and palette index = triangle_id[log2(PALETTE_DEPTH)-1:0].
- S2: synchronous palette read. A write to the same address in the same cycle returns the old data (read-first). Palette writes are never blocked by a stall.
- S3 (colour select):
  - FLAT: FLAT_COLOR.
  - PALETTE: palette entry.
  - DEPTH_SHADE: each 4-bit channel c' = (c * (2^Z_WIDTH - z)) >> Z_WIDTH. This uses an unsigned (Z_WIDTH+1)-bit scale and a (Z_WIDTH+5)-bit product. z=0 leaves the colour unchanged.
  - ID_DEBUG: triangle_id[11:0], zero-extended if ID_WIDTH<12.
- Mode is sampled per fragment at S1, so a mode change affects only later fragments.
- frag_count_out increments on each valid_out && ready_in. Counters wrap at 2^32.
- frame_start_in: both counters become 0. Clear takes priority over a simultaneous increment.

Decomposition:
- Package graphics_pkg:
  - shade_mode_t enum (FLAT, PALETTE, DEPTH_SHADE, ID_DEBUG)
  - rgb444_t typedef
  - default SCREEN_WIDTH/SCREEN_HEIGHT constants
- Sub-module palette_ram: parametrised depth, 12-bit, one write port, one synchronous read-first read port with read enable = en.

Test Plan:
- PALETTE mode, pal[3]=12'hF84, triangle_id=3, x=0x00A00, y=0x01400, z=0x00000, ready_in=1 -> 3 cycles later valid_out, x=10, y=20, z=0, rgb=F84; frag_count=1.
- DEPTH_SHADE, pal[3]=F84, z coord=0x10000 (z=128) -> rgb=12'h742, z_out=128.
- x coord=0x14000 (320) or y coord=0x0F000 (240) -> no valid_out, clip_count=1; x=319/y=239 pass.
- Stream of 6 fragments with ready_in low for 4 cycles after first output -> ready_out low, outputs held, all 6 emitted in order with no loss or duplication.
- Mode switch FLAT->ID_DEBUG between consecutive fragments (id=0x0ABC) -> first rgb=AAA, second rgb=ABC. Palette write to the addressed entry while a fragment is in S2 -> old colour returned.
- frame_start_in asserted with a handshake in the same cycle -> frag_count_out=0 next cycle. rst_in with 3 fragments in flight -> no valid_out afterwards, counters 0.

Source files
------------

// File: rtl/graphics_pkg.sv
// Shared types and constants for the fragment shading path.
package graphics_pkg;

   typedef enum logic [1:0] {
      FLAT        = 2'd0,
      PALETTE     = 2'd1,
      DEPTH_SHADE = 2'd2,
      ID_DEBUG    = 2'd3
   } shade_mode_t;

   typedef logic [11:0] rgb444_t;

   localparam int unsigned DEFAULT_SCREEN_WIDTH  = 320;
   localparam int unsigned DEFAULT_SCREEN_HEIGHT = 240;

endpackage

// File: rtl/palette_ram.sv
// Writable RGB444 palette: one write port, one registered read-first read port.
module palette_ram
   import graphics_pkg::*;
#(
   parameter  int unsigned DEPTH = 16,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_in,
   input  logic          we_in,
   input  logic [AW-1:0] waddr_in,
   input  rgb444_t       wdata_in,
   input  logic          re_in,
   input  logic [AW-1:0] raddr_in,
   output rgb444_t       rdata_out
);

   rgb444_t mem [DEPTH];

   // Write is independent of re_in so palette updates land even during a stall.
   always_ff @(posedge clk_in) begin
      if (we_in) begin
         mem[waddr_in] <= wdata_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (re_in) begin
         rdata_out <= mem[raddr_in];
      end
   end

endmodule

// File: rtl/fragment_shade_stage.sv
// Three-stage fragment shader: decode/clip, palette read, colour select,
// with valid/ready backpressure and per-frame fragment/clip counters.
module fragment_shade_stage
   import graphics_pkg::*;
#(
   parameter  int unsigned COORD_WIDTH   = 17,
   parameter  int unsigned FRAC_BITS     = 8,
   parameter  int unsigned X_WIDTH       = 9,
   parameter  int unsigned Y_WIDTH       = 8,
   parameter  int unsigned Z_WIDTH       = 8,
   parameter  int unsigned Z_LSB         = 9,
   parameter  int unsigned ID_WIDTH      = 16,
   parameter  int unsigned SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
   parameter  int unsigned SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
   parameter  int unsigned PALETTE_DEPTH = 16,
   parameter  rgb444_t     FLAT_COLOR    = 12'hAAA,
   localparam int unsigned PAL_AW        = $clog2(PALETTE_DEPTH)
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            valid_in,
   output logic                            ready_out,
   input  logic [ID_WIDTH-1:0]             triangle_id_in,
   input  logic [2:0][COORD_WIDTH-1:0]     fragment_in,
   input  logic [1:0]                      mode_in,
   input  logic                            pal_we_in,
   input  logic [PAL_AW-1:0]               pal_addr_in,
   input  logic [11:0]                     pal_data_in,
   input  logic                            frame_start_in,
   output logic                            valid_out,
   input  logic                            ready_in,
   output logic [X_WIDTH-1:0]              x_out,
   output logic [Y_WIDTH-1:0]              y_out,
   output logic [Z_WIDTH-1:0]              z_out,
   output logic [11:0]                     rgb_out,
   output logic [31:0]                     frag_count_out,
   output logic [31:0]                     clip_count_out
);

   localparam logic [Z_WIDTH:0] Z_FULL = {1'b1, {Z_WIDTH{1'b0}}};

   function automatic logic [3:0] shade_ch(input logic [3:0] c, input logic [Z_WIDTH:0] scale);
      logic [Z_WIDTH+4:0] prod;
      prod = (Z_WIDTH+5)'(c) * (Z_WIDTH+5)'(scale);
      return 4'(prod >> Z_WIDTH);
   endfunction

   logic en;
   logic accept;
   logic clip;
   logic [COORD_WIDTH-1:0] xi;
   logic [COORD_WIDTH-1:0] yi;

   logic                s1_valid;
   logic [X_WIDTH-1:0]  s1_x;
   logic [Y_WIDTH-1:0]  s1_y;
   logic [Z_WIDTH-1:0]  s1_z;
   shade_mode_t         s1_mode;
   rgb444_t             s1_dbg;
   logic [PAL_AW-1:0]   s1_pal_idx;

   logic                s2_valid;
   logic [X_WIDTH-1:0]  s2_x;
   logic [Y_WIDTH-1:0]  s2_y;
   logic [Z_WIDTH-1:0]  s2_z;
   shade_mode_t         s2_mode;
   rgb444_t             s2_dbg;

   rgb444_t             pal_rdata;
   rgb444_t             s3_rgb;
   logic [Z_WIDTH:0]    scale;

   logic unused_bits;
   assign unused_bits = ^{fragment_in, triangle_id_in};

   assign en        = !valid_out || ready_in;
   assign ready_out = en;
   assign accept    = valid_in && en;

   assign xi   = fragment_in[0] >> FRAC_BITS;
   assign yi   = fragment_in[1] >> FRAC_BITS;
   assign clip = (xi >= COORD_WIDTH'(SCREEN_WIDTH)) || (yi >= COORD_WIDTH'(SCREEN_HEIGHT));

   palette_ram #(
      .DEPTH (PALETTE_DEPTH)
   ) u_palette (
      .clk_in    (clk_in),
      .we_in     (pal_we_in),
      .waddr_in  (pal_addr_in),
      .wdata_in  (pal_data_in),
      .re_in     (en),
      .raddr_in  (s1_pal_idx),
      .rdata_out (pal_rdata)
   );

   assign scale = Z_FULL - {1'b0, s2_z};

   always_comb begin
      s3_rgb = FLAT_COLOR;
      case (s2_mode)
         FLAT:        s3_rgb = FLAT_COLOR;
         PALETTE:     s3_rgb = pal_rdata;
         DEPTH_SHADE: s3_rgb = {shade_ch(pal_rdata[11:8], scale),
                                shade_ch(pal_rdata[7:4],  scale),
                                shade_ch(pal_rdata[3:0],  scale)};
         ID_DEBUG:    s3_rgb = s2_dbg;
         default:     s3_rgb = FLAT_COLOR;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_valid   <= 1'b0;
         s1_x       <= '0;
         s1_y       <= '0;
         s1_z       <= '0;
         s1_mode    <= FLAT;
         s1_dbg     <= '0;
         s1_pal_idx <= '0;
         s2_valid   <= 1'b0;
         s2_x       <= '0;
         s2_y       <= '0;
         s2_z       <= '0;
         s2_mode    <= FLAT;
         s2_dbg     <= '0;
         valid_out  <= 1'b0;
         x_out      <= '0;
         y_out      <= '0;
         z_out      <= '0;
         rgb_out    <= '0;
      end else if (en) begin
         s1_valid   <= valid_in && !clip;
         s1_x       <= xi[X_WIDTH-1:0];
         s1_y       <= yi[Y_WIDTH-1:0];
         s1_z       <= fragment_in[2][Z_LSB+Z_WIDTH-1:Z_LSB];
         s1_mode    <= shade_mode_t'(mode_in);
         s1_dbg     <= 12'(triangle_id_in);
         s1_pal_idx <= triangle_id_in[PAL_AW-1:0];
         s2_valid   <= s1_valid;
         s2_x       <= s1_x;
         s2_y       <= s1_y;
         s2_z       <= s1_z;
         s2_mode    <= s1_mode;
         s2_dbg     <= s1_dbg;
         valid_out  <= s2_valid;
         if (s2_valid) begin
            x_out   <= s2_x;
            y_out   <= s2_y;
            z_out   <= s2_z;
            rgb_out <= s3_rgb;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in || frame_start_in) begin
         frag_count_out <= '0;
         clip_count_out <= '0;
      end else begin
         if (valid_out && ready_in) begin
            frag_count_out <= frag_count_out + 32'd1;
         end
         if (accept && clip) begin
            clip_count_out <= clip_count_out + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_fragment_shade_stage.sv
// Directed, table-driven bench for fragment_shade_stage with hand sequences
// for backpressure, mode switching, palette collision, frame start and reset.
module tb_fragment_shade_stage;
   import graphics_pkg::*;

   logic              clk_in = 1'b0;
   logic              rst_in;
   logic              valid_in;
   logic              ready_out;
   logic [15:0]       triangle_id_in;
   logic [2:0][16:0]  fragment_in;
   logic [1:0]        mode_in;
   logic              pal_we_in;
   logic [3:0]        pal_addr_in;
   logic [11:0]       pal_data_in;
   logic              frame_start_in;
   logic              valid_out;
   logic              ready_in;
   logic [8:0]        x_out;
   logic [7:0]        y_out;
   logic [7:0]        z_out;
   logic [11:0]       rgb_out;
   logic [31:0]       frag_count_out;
   logic [31:0]       clip_count_out;

   always #5 clk_in = ~clk_in;

   fragment_shade_stage #(
      .SCREEN_WIDTH  (320),
      .SCREEN_HEIGHT (240),
      .FLAT_COLOR    (12'hAAA)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .valid_in       (valid_in),
      .ready_out      (ready_out),
      .triangle_id_in (triangle_id_in),
      .fragment_in    (fragment_in),
      .mode_in        (mode_in),
      .pal_we_in      (pal_we_in),
      .pal_addr_in    (pal_addr_in),
      .pal_data_in    (pal_data_in),
      .frame_start_in (frame_start_in),
      .valid_out      (valid_out),
      .ready_in       (ready_in),
      .x_out          (x_out),
      .y_out          (y_out),
      .z_out          (z_out),
      .rgb_out        (rgb_out),
      .frag_count_out (frag_count_out),
      .clip_count_out (clip_count_out)
   );

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] id;
      logic [16:0] fx;
      logic [16:0] fy;
      logic [16:0] fz;
      bit          clip;
      logic [8:0]  ex;
      logic [7:0]  ey;
      logic [7:0]  ez;
      logic [11:0] erg;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_frag = 0;
   int exp_clip = 0;

   logic [11:0] got_rgb [8];
   logic [8:0]  got_x   [8];
   int          got_n;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_frag(input logic [1:0] mode, input logic [15:0] id,
                             input logic [16:0] fx, input logic [16:0] fy, input logic [16:0] fz);
      valid_in       = 1'b1;
      mode_in        = mode;
      triangle_id_in = id;
      fragment_in    = {fz, fy, fx};
   endtask

   task automatic send(input logic [1:0] mode, input logic [15:0] id,
                       input logic [16:0] fx, input logic [16:0] fy, input logic [16:0] fz);
      drive_frag(mode, id, fx, fy, fz);
      tick();
      valid_in = 1'b0;
   endtask

   task automatic pal_write(input logic [3:0] addr, input logic [11:0] data);
      pal_we_in   = 1'b1;
      pal_addr_in = addr;
      pal_data_in = data;
      tick();
      pal_we_in   = 1'b0;
   endtask

   task automatic collect(input int n, input int budget);
      got_n = 0;
      for (int i = 0; i < budget; i++) begin
         if (valid_out && ready_in && got_n < 8) begin
            got_rgb[got_n] = rgb_out;
            got_x[got_n]   = x_out;
            got_n++;
         end
         tick();
         if (got_n >= n) break;
      end
   endtask

   vec_t vecs [10];

   initial begin
      int lat;
      int seen;
      int sent;
      int recv;
      int stall_left;
      bit first_seen;
      bit acc;
      bit hs;
      logic [8:0] held_x;

      vecs[0] = '{2'd1, 16'h0003, 17'h00A00, 17'h01400, 17'h00000, 1'b0, 9'd10,  8'd20,  8'd0,   12'hF84};
      vecs[1] = '{2'd2, 16'h0003, 17'h00A00, 17'h01400, 17'h10000, 1'b0, 9'd10,  8'd20,  8'd128, 12'h742};
      vecs[2] = '{2'd0, 16'h0007, 17'h13F00, 17'h0EF00, 17'h1FE00, 1'b0, 9'd319, 8'd239, 8'd255, 12'hAAA};
      vecs[3] = '{2'd1, 16'h0003, 17'h14000, 17'h01400, 17'h00000, 1'b1, 9'd0,   8'd0,   8'd0,   12'h000};
      vecs[4] = '{2'd1, 16'h0003, 17'h00A00, 17'h0F000, 17'h00000, 1'b1, 9'd0,   8'd0,   8'd0,   12'h000};
      vecs[5] = '{2'd3, 16'h0ABC, 17'h000FF, 17'h001FF, 17'h00200, 1'b0, 9'd0,   8'd1,   8'd1,   12'hABC};
      vecs[6] = '{2'd2, 16'h0015, 17'h00100, 17'h00100, 17'h1FE00, 1'b0, 9'd1,   8'd1,   8'd255, 12'h000};
      vecs[7] = '{2'd2, 16'h0010, 17'h00200, 17'h00300, 17'h00200, 1'b0, 9'd2,   8'd3,   8'd1,   12'hEEE};
      vecs[8] = '{2'd1, 16'hFFF3, 17'h00500, 17'h00600, 17'h00000, 1'b0, 9'd5,   8'd6,   8'd0,   12'hF84};
      vecs[9] = '{2'd1, 16'h0003, 17'h1FF00, 17'h00000, 17'h00000, 1'b1, 9'd0,   8'd0,   8'd0,   12'h000};

      rst_in = 1'b1; valid_in = 1'b0; ready_in = 1'b1; frame_start_in = 1'b0;
      pal_we_in = 1'b0; pal_addr_in = '0; pal_data_in = '0;
      mode_in = '0; triangle_id_in = '0; fragment_in = '0;
      repeat (3) tick();
      rst_in = 1'b0;

      check("rst_valid_out", 32'(valid_out), 32'd0);
      check("rst_x_out",     32'(x_out),     32'd0);
      check("rst_rgb_out",   32'(rgb_out),   32'd0);
      check("rst_frag",      frag_count_out, 32'd0);
      check("rst_clip",      clip_count_out, 32'd0);
      check("rst_ready",     32'(ready_out), 32'd1);

      pal_write(4'd3, 12'hF84);
      pal_write(4'd5, 12'h123);
      pal_write(4'd0, 12'hFFF);

      for (int v = 0; v < 10; v++) begin
         send(vecs[v].mode, vecs[v].id, vecs[v].fx, vecs[v].fy, vecs[v].fz);
         if (vecs[v].clip) begin
            seen = 0;
            for (int i = 0; i < 5; i++) begin
               if (valid_out) seen++;
               tick();
            end
            exp_clip++;
            check($sformatf("v%0d_clip_no_out", v), 32'(seen), 32'd0);
            check($sformatf("v%0d_clip_count", v), clip_count_out, 32'(exp_clip));
         end else begin
            lat = 0;
            for (int i = 0; i < 8; i++) begin
               tick();
               lat++;
               if (valid_out) break;
            end
            check($sformatf("v%0d_latency", v), 32'(lat), 32'd2);
            check($sformatf("v%0d_x", v),   32'(x_out),   32'(vecs[v].ex));
            check($sformatf("v%0d_y", v),   32'(y_out),   32'(vecs[v].ey));
            check($sformatf("v%0d_z", v),   32'(z_out),   32'(vecs[v].ez));
            check($sformatf("v%0d_rgb", v), 32'(rgb_out), 32'(vecs[v].erg));
            tick();
            exp_frag++;
            check($sformatf("v%0d_frag_count", v), frag_count_out, 32'(exp_frag));
         end
      end

      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      check("fs_frag_clear", frag_count_out, 32'd0);
      check("fs_clip_clear", clip_count_out, 32'd0);

      // Backpressure stream: ID_DEBUG colour carries the sequence number.
      sent = 0; recv = 0; stall_left = 0; first_seen = 1'b0; held_x = '0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (valid_out && !first_seen) begin
            first_seen = 1'b1;
            stall_left = 4;
         end
         ready_in = !(stall_left > 0);
         if (sent < 6) drive_frag(2'd3, 16'(sent + 1), 17'((sent + 1) << 8), 17'h00100, 17'h00000);
         else valid_in = 1'b0;
         #1;
         if (stall_left > 0) begin
            check("stall_ready_low", 32'(ready_out), 32'd0);
            if (stall_left < 4) check("stall_x_held", 32'(x_out), 32'(held_x));
         end
         acc = valid_in && ready_out;
         hs  = valid_out && ready_in;
         if (hs) begin
            check($sformatf("stream_x%0d", recv), 32'(x_out), 32'(recv + 1));
            check($sformatf("stream_rgb%0d", recv), 32'(rgb_out), 32'(recv + 1));
            recv++;
         end
         held_x = x_out;
         @(posedge clk_in);
         #1;
         if (acc) sent++;
         if (stall_left > 0) stall_left--;
         if (sent == 6 && recv == 6) break;
      end
      valid_in = 1'b0;
      ready_in = 1'b1;
      check("stream_recv", 32'(recv), 32'd6);
      seen = 0;
      for (int i = 0; i < 4; i++) begin
         if (valid_out) seen++;
         tick();
      end
      check("stream_no_dup", 32'(seen), 32'd0);
      check("stream_frag_count", frag_count_out, 32'd6);

      drive_frag(2'd0, 16'h0ABC, 17'h00100, 17'h00100, 17'h00000);
      tick();
      drive_frag(2'd3, 16'h0ABC, 17'h00200, 17'h00100, 17'h00000);
      tick();
      valid_in = 1'b0;
      collect(2, 10);
      check("modesw_n",    32'(got_n),      32'd2);
      check("modesw_rgb0", 32'(got_rgb[0]), 32'hAAA);
      check("modesw_rgb1", 32'(got_rgb[1]), 32'hABC);

      // Overwrite pal[3] on the same edge the in-flight fragment reads it.
      send(2'd1, 16'h0003, 17'h00300, 17'h00100, 17'h00000);
      pal_write(4'd3, 12'h111);
      collect(1, 10);
      check("palcol_n",   32'(got_n),      32'd1);
      check("palcol_old", 32'(got_rgb[0]), 32'hF84);
      send(2'd1, 16'h0003, 17'h00300, 17'h00100, 17'h00000);
      collect(1, 10);
      check("palcol_new", 32'(got_rgb[0]), 32'h111);
      check("palcol_frag_count", frag_count_out, 32'd10);

      send(2'd0, 16'h0001, 17'h00100, 17'h00100, 17'h00000);
      for (int i = 0; i < 8; i++) begin
         if (valid_out) break;
         tick();
      end
      check("fshs_valid", 32'(valid_out), 32'd1);
      frame_start_in = 1'b1;
      tick();
      frame_start_in = 1'b0;
      check("fshs_frag_zero", frag_count_out, 32'd0);

      send(2'd0, 16'h0001, 17'h00100, 17'h00100, 17'h00000);
      send(2'd0, 16'h0002, 17'h00200, 17'h00100, 17'h00000);
      send(2'd0, 16'h0003, 17'h00300, 17'h00100, 17'h00000);
      send(2'd1, 16'h0003, 17'h14000, 17'h00100, 17'h00000);
      rst_in = 1'b1;
      tick();
      rst_in = 1'b0;
      check("midrst_valid", 32'(valid_out), 32'd0);
      check("midrst_frag",  frag_count_out, 32'd0);
      check("midrst_clip",  clip_count_out, 32'd0);
      check("midrst_x",     32'(x_out),     32'd0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (valid_out) seen++;
         tick();
      end
      check("midrst_no_out", 32'(seen), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
